// File: rtl/bec_pkg.sv
// Shared constants and state encoding for the BEC core result/load datapaths.
package bec_pkg;

  localparam int BEC_DATA_W    = 163;
  localparam int BEC_WORD_W    = 32;
  localparam int BEC_NUM_WORDS = (BEC_DATA_W + BEC_WORD_W - 1) / BEC_WORD_W;
  localparam int BEC_IDX_W     = $clog2(BEC_NUM_WORDS);
  localparam int BEC_STATUS_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } bec_state_e;

endpackage

// File: rtl/bec_word_mux.sv
// Selects word idx_i (LSW first) from the wide result, zero-padding the top word.
// Purely combinational; out-of-range indices return zero.
module bec_word_mux
  import bec_pkg::*;
#(
  parameter int  DATA_W    = BEC_DATA_W,
  parameter int  WORD_W    = BEC_WORD_W,
  localparam int NUM_WORDS = (DATA_W + WORD_W - 1) / WORD_W,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic [DATA_W-1:0] shadow_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [WORD_W-1:0] word_o
);

  localparam int PAD_W = NUM_WORDS * WORD_W;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(shadow_i);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx_i == IDX_W'(i)) begin
        word_o = padded[i*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/bec_result_unloader.sv
// Shadows the BEC core result on each done rise and streams it as WORD_W words, LSW first.
// First word valid 1 cycle after the rise; words hold while m_ready_i is low; a rise mid-frame is dropped and flagged.
module bec_result_unloader
  import bec_pkg::*;
#(
  parameter int  DATA_W    = BEC_DATA_W,
  parameter int  WORD_W    = BEC_WORD_W,
  localparam int NUM_WORDS = (DATA_W + WORD_W - 1) / WORD_W,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    done_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic [BEC_STATUS_W-1:0] status_i,
  input  logic                    abort_i,
  input  logic                    ovf_clr_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [WORD_W-1:0]       m_data_o,
  output logic [IDX_W-1:0]        m_idx_o,
  output logic                    m_last_o,
  output logic [BEC_STATUS_W-1:0] status_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic [7:0]              frames_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  bec_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic [BEC_STATUS_W-1:0] status_q, status_d;
  logic [7:0]              frames_q, frames_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q;

  logic              rise;
  logic              sending;
  logic              hs;
  logic              last_hs;
  logic              capture;
  logic              ovf_set;
  logic [WORD_W-1:0] mux_word;

  assign rise    = done_i & ~done_q;
  assign sending = (state_q == SEND);
  assign hs      = sending & m_ready_i;
  assign last_hs = hs & (idx_q == LAST_IDX);
  // A new result is taken whenever the shadow is free by the end of this cycle.
  assign capture = rise & (~sending | abort_i | last_hs);
  assign ovf_set = rise & sending & ~abort_i & ~last_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      status_q <= '0;
      frames_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      status_q <= status_d;
      frames_q <= frames_d;
      ovf_q    <= ovf_d;
      done_q   <= done_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    status_d = status_q;
    frames_d = frames_q;

    case (state_q)
      IDLE: ;
      SEND: begin
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (last_hs) begin
          state_d  = IDLE;
          idx_d    = '0;
          frames_d = frames_q + 8'd1;
        end else if (hs) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d  = SEND;
      idx_d    = '0;
      shadow_d = data_i;
      status_d = status_i;
    end
  end

  // Set beats clear so an overrun landing on the clear pulse is not lost.
  assign ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);

  bec_word_mux #(
    .DATA_W (DATA_W),
    .WORD_W (WORD_W)
  ) u_word_mux (
    .shadow_i (shadow_q),
    .idx_i    (idx_q),
    .word_o   (mux_word)
  );

  assign m_valid_o = sending;
  assign busy_o    = sending;
  assign m_data_o  = sending ? mux_word : '0;
  assign m_idx_o   = idx_q;
  assign m_last_o  = sending & (idx_q == LAST_IDX);
  assign status_o  = status_q;
  assign overrun_o = ovf_q;
  assign frames_o  = frames_q;

endmodule

// File: tb/tb_bec_result_unloader.sv
// Randomised and directed bench for bec_result_unloader with a queue-based reference model and scoreboard.
module tb_bec_result_unloader;

  localparam int DW = 163;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          done_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [3:0]    status_i = '0;
  logic          abort_i = 1'b0;
  logic          ovf_clr_i = 1'b0;
  logic          m_ready_i = 1'b0;
  logic          m_valid_o;
  logic [31:0]   m_data_o;
  logic [2:0]    m_idx_o;
  logic          m_last_o;
  logic [3:0]    status_o;
  logic          busy_o;
  logic          overrun_o;
  logic [7:0]    frames_o;

  always #5 clk = ~clk;

  bec_result_unloader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .done_i    (done_i),
    .data_i    (data_i),
    .status_i  (status_i),
    .abort_i   (abort_i),
    .ovf_clr_i (ovf_clr_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_idx_o   (m_idx_o),
    .m_last_o  (m_last_o),
    .status_o  (status_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o),
    .frames_o  (frames_o)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic [2:0]  idx;
    logic        last;
  } word_t;

  word_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int valid_cycles = 0;

  // Reference model state: frame in flight and the words still owed to the sink.
  bit         m_busy = 1'b0;
  bit         m_done_q = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_rem = 0;
  logic [7:0] m_frames = '0;
  logic [3:0] m_status = '0;
  bit         r_rise;
  bit         r_set;

  logic [DW-1:0] d1 = 163'h5_0123_4567_89ab_cdef_fedc_ba98_7654_3210_1122_3344;
  logic [DW-1:0] d2, d3, d4;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [191:0] r;
    for (int k = 0; k < 6; k++) r[k*32 +: 32] = $urandom;
    return r[DW-1:0];
  endfunction

  function automatic void model_capture(input logic [DW-1:0] d, input logic [3:0] s);
    word_t w;
    m_busy   = 1'b1;
    m_rem    = NW;
    m_status = s;
    for (int k = 0; k < NW; k++) begin
      w.dat  = 32'(d >> (32 * k));
      w.idx  = 3'(k);
      w.last = (k == NW - 1);
      sb_q.push_back(w);
    end
  endfunction

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_done_q = 1'b0;
      m_ovf    = 1'b0;
      m_rem    = 0;
      m_frames = '0;
      m_status = '0;
      sb_q.delete();
    end else begin
      r_rise   = done_i && !m_done_q;
      m_done_q = done_i;
      r_set    = 1'b0;
      if (!m_busy) begin
        if (r_rise) model_capture(data_i, status_i);
      end else if (abort_i) begin
        for (int k = 0; k < m_rem; k++) if (sb_q.size() > 0) void'(sb_q.pop_back());
        m_busy = 1'b0;
        m_rem  = 0;
        if (r_rise) model_capture(data_i, status_i);
      end else if (m_ready_i && m_rem == 1) begin
        m_frames = m_frames + 8'd1;
        m_busy   = 1'b0;
        m_rem    = 0;
        if (r_rise) model_capture(data_i, status_i);
      end else begin
        if (m_ready_i) m_rem = m_rem - 1;
        if (r_rise) r_set = 1'b1;
      end
      if (r_set) m_ovf = 1'b1;
      else if (ovf_clr_i) m_ovf = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (rst_n) begin
      chk("valid", 32'(m_valid_o), 32'(m_busy));
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("frames", 32'(frames_o), 32'(m_frames));
      chk("overrun", 32'(overrun_o), 32'(m_ovf));
      chk("status", 32'(status_o), 32'(m_status));
      if (m_valid_o) begin
        valid_cycles++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: word idx %0d data %h presented with none expected", m_idx_o, m_data_o);
        end else begin
          chk("data", m_data_o, sb_q[0].dat);
          chk("idx", 32'(m_idx_o), 32'(sb_q[0].idx));
          chk("last", 32'(m_last_o), 32'(sb_q[0].last));
          if (m_ready_i && !abort_i) void'(sb_q.pop_front());
        end
      end else begin
        chk("last_idle", 32'(m_last_o), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] d, input logic [3:0] s);
    data_i   = d;
    status_i = s;
    done_i   = 1'b1;
    tick();
    done_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(m_valid_o), 32'd0);
    chk({tag, "_data"}, m_data_o, 32'd0);
    chk({tag, "_idx"}, 32'(m_idx_o), 32'd0);
    chk({tag, "_last"}, 32'(m_last_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_ovf"}, 32'(overrun_o), 32'd0);
    chk({tag, "_frames"}, 32'(frames_o), 32'd0);
    chk({tag, "_status"}, 32'(status_o), 32'd0);
  endtask

  initial begin
    d2 = rnd_data();
    d3 = rnd_data();
    d4 = rnd_data();

    #3;
    chk_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single frame, sink always ready: six consecutive words.
    m_ready_i    = 1'b1;
    valid_cycles = 0;
    pulse(d1, 4'hA);
    chk("t1_first_word", m_data_o, 32'h1122_3344);
    repeat (8) tick();
    chk("t1_cycles", 32'(valid_cycles), 32'd6);
    chk("t1_frames", 32'(frames_o), 32'd1);
    chk("t1_status", 32'(status_o), 32'hA);

    // Alternating backpressure starting stalled: twelve valid cycles.
    m_ready_i    = 1'b0;
    valid_cycles = 0;
    pulse(d2, 4'h3);
    for (int i = 0; i < 14; i++) begin
      m_ready_i = i[0];
      tick();
    end
    chk("t2_cycles", 32'(valid_cycles), 32'd12);
    chk("t2_frames", 32'(frames_o), 32'd2);

    // Second rise while idx 2 is on the bus is dropped and flagged.
    m_ready_i = 1'b1;
    pulse(d1, 4'h1);
    tick();
    tick();
    pulse(d3, 4'hF);
    chk("t3_overrun_set", 32'(overrun_o), 32'd1);
    repeat (5) tick();
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    chk("t3_overrun_clr", 32'(overrun_o), 32'd0);
    chk("t3_frames", 32'(frames_o), 32'd3);

    // Rise on the last handshake chains straight into the next frame.
    pulse(d2, 4'h5);
    repeat (5) tick();
    pulse(d4, 4'h6);
    chk("t4_idx", 32'(m_idx_o), 32'd0);
    chk("t4_word0", m_data_o, d4[31:0]);
    chk("t4_overrun", 32'(overrun_o), 32'd0);
    chk("t4_frames", 32'(frames_o), 32'd4);
    repeat (8) tick();

    // Abort at idx 3, then a fresh frame.
    pulse(d1, 4'h7);
    repeat (3) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t5_valid_after_abort", 32'(m_valid_o), 32'd0);
    chk("t5_frames", 32'(frames_o), 32'd5);
    pulse(d3, 4'h2);
    chk("t5_new_idx", 32'(m_idx_o), 32'd0);
    chk("t5_new_word0", m_data_o, d3[31:0]);
    repeat (8) tick();
    chk("t5_frames_done", 32'(frames_o), 32'd6);

    // Asynchronous reset at idx 4 with done held high through release.
    pulse(d2, 4'h4);
    repeat (4) tick();
    #2;
    rst_n    = 1'b0;
    done_i   = 1'b1;
    data_i   = d4;
    status_i = 4'h9;
    #1;
    chk_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    done_i = 1'b0;
    repeat (4) tick();
    chk("t6_frames", 32'(frames_o), 32'd1);
    chk("t6_status", 32'(status_o), 32'h9);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      m_ready_i = ($urandom_range(0, 9) < 7);
      done_i    = ($urandom_range(0, 4) == 0);
      abort_i   = ($urandom_range(0, 49) == 0);
      ovf_clr_i = ($urandom_range(0, 19) == 0);
      data_i    = rnd_data();
      status_i  = 4'($urandom);
      tick();
    end
    done_i    = 1'b0;
    abort_i   = 1'b0;
    ovf_clr_i = 1'b0;
    m_ready_i = 1'b1;
    repeat (10) tick();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    chk("drain_valid", 32'(m_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
